// File: rtl/wb_spimemio_arb.sv
// wb_spimemio_arb: two-master Wishbone arbiter/sequencer in front of the SPI flash
// read controller. Keeps at most one downstream read in flight. Each master
// request is granted round-robin or with fixed priority (m0 wins ties). A hung
// slave is aborted after TIMEOUT cycles in WAIT.
//
// Optional feature: define WB_SPIARB_HIT_BUF_EN to add a one-entry last-word
// hit buffer. When it is not defined, cache_inv_i is unused.
//
// Ports:
//   wb_clk_i, wb_rst_i              clock; asynchronous active-high reset
//   m0_*/m1_*                       master ports: adr/cyc/stb in, dat/ack/err out
//                                   (ack and err are 1-cycle pulses)
//   s_adr_o/s_cyc_o/s_stb_o         downstream request (registered)
//   s_dat_i/s_ack_i                 downstream response
//   cache_inv_i                     clear the hit buffer
module wb_spimemio_arb #(
  parameter int unsigned ADR_W      = 24,
  parameter int unsigned TIMEOUT    = 1023,
  parameter int unsigned PRIO_FIXED = 0
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  output logic [31:0]      m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  output logic [31:0]      m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  input  logic [31:0]      s_dat_i,
  input  logic             s_ack_i,
  input  logic             cache_inv_i
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [ADR_W-1:0] s_adr_q, s_adr_d;
  logic             s_req_q, s_req_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;
  // WAIT entered from a buffer hit: no downstream read, respond next cycle.
  logic             hit_q, hit_d;
  logic [31:0]      dat0_q, dat0_d, dat1_q, dat1_d;

  logic             live0, live1, live_gnt, req0, req1;
  logic             sel;
  logic [ADR_W-1:0] sel_adr;
  logic             buf_hit;
  logic [31:0]      buf_dat;
  logic             resp_ok;

  assign live0    = m0_cyc_i & m0_stb_i;
  assign live1    = m1_cyc_i & m1_stb_i;
  assign live_gnt = gnt_q ? live1 : live0;

  // Responses are gated by the live request so a master that gave up gets nothing.
  assign resp_ok  = (state_q == StResp);
  assign m0_ack_o = resp_ok & ~gnt_q & ~err_q & live0;
  assign m1_ack_o = resp_ok &  gnt_q & ~err_q & live1;
  assign m0_err_o = resp_ok & ~gnt_q &  err_q & live0;
  assign m1_err_o = resp_ok &  gnt_q &  err_q & live1;

  assign req0 = live0 & ~m0_ack_o & ~m0_err_o;
  assign req1 = live1 & ~m1_ack_o & ~m1_err_o;

  // On a tie, round-robin picks the master that did not win last time.
  always_comb begin
    if (req0 && req1) sel = (PRIO_FIXED != 0) ? 1'b0 : ~last_q;
    else              sel = req1;
  end
  assign sel_adr = sel ? m1_adr_i : m0_adr_i;

`ifdef WB_SPIARB_HIT_BUF_EN
  logic             buf_vld_q, buf_vld_d;
  logic [ADR_W-1:0] buf_adr_q, buf_adr_d;
  logic [31:0]      buf_dat_q, buf_dat_d;

  // Every successful downstream read refills the buffer, even when the result is
  // discarded. Invalidate wins over a same-cycle load.
  always_comb begin
    buf_vld_d = buf_vld_q;
    buf_adr_d = buf_adr_q;
    buf_dat_d = buf_dat_q;
    if (state_q == StWait && !hit_q && s_ack_i) begin
      buf_vld_d = 1'b1;
      buf_adr_d = s_adr_q;
      buf_dat_d = s_dat_i;
    end
    if (cache_inv_i) buf_vld_d = 1'b0;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      buf_vld_q <= 1'b0;
      buf_adr_q <= '0;
      buf_dat_q <= '0;
    end else begin
      buf_vld_q <= buf_vld_d;
      buf_adr_q <= buf_adr_d;
      buf_dat_q <= buf_dat_d;
    end
  end

  assign buf_hit = buf_vld_q && (buf_adr_q == sel_adr);
  assign buf_dat = buf_dat_q;
`else
  logic unused_cache_inv;
  assign unused_cache_inv = cache_inv_i;
  assign buf_hit          = 1'b0;
  assign buf_dat          = '0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    s_adr_d = s_adr_q;
    s_req_d = s_req_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    hit_d   = hit_q;
    dat0_d  = dat0_q;
    dat1_d  = dat1_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          gnt_d   = sel;
          last_d  = sel;
          s_adr_d = sel_adr;
          s_req_d = ~buf_hit;
          hit_d   = buf_hit;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (hit_q || s_ack_i) begin
          s_req_d = 1'b0;
          state_d = StResp;
          if (live_gnt) begin
            if (gnt_q) dat1_d = hit_q ? buf_dat : s_dat_i;
            else       dat0_d = hit_q ? buf_dat : s_dat_i;
          end
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          s_req_d = 1'b0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      s_adr_q <= '0;
      s_req_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      hit_q   <= 1'b0;
      dat0_q  <= '0;
      dat1_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      s_adr_q <= s_adr_d;
      s_req_q <= s_req_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      hit_q   <= hit_d;
      dat0_q  <= dat0_d;
      dat1_q  <= dat1_d;
    end
  end

  assign s_adr_o  = s_adr_q;
  assign s_cyc_o  = s_req_q;
  assign s_stb_o  = s_req_q;
  assign m0_dat_o = dat0_q;
  assign m1_dat_o = dat1_q;

endmodule
